// File: rtl/sram_tp_param.sv
// Parametrised two-port (1W/1R) synchronous SRAM with byte enables, optional
// output pipeline stage, write-first collision forwarding and post-reset zero clear.
module sram_tp_param #(
   parameter int DW       = 32,
   parameter int AW       = 12,
   parameter int RD_PIPE  = 0,
   parameter int INIT_CLR = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_wen,
   input  logic [DW/8-1:0] i_wbe,
   input  logic [AW-1:0]   i_waddr,
   input  logic [DW-1:0]   i_wd,
   input  logic            i_ren,
   input  logic [AW-1:0]   i_raddr,
   output logic [DW-1:0]   o_rd,
   output logic            o_rvalid,
   output logic            o_busy
);

   localparam int NB = DW / 8;

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW:0]     r_cnt;
   logic [AW:0]     w_cnt_nxt;
   logic            w_clr_we;

   logic            w_we;
   logic [NB-1:0]   w_wbe;
   logic [AW-1:0]   w_waddr;
   logic [DW-1:0]   w_wdata;
   logic            w_ren_acc;
   logic [NB-1:0]   w_fwd;

   logic [DW-1:0]   r_mem [2**AW];
   logic [DW-1:0]   r_d1;
   logic            r_v1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= (INIT_CLR != 0) ? S_CLEAR : S_READY;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            o_busy    = 1'b1;
            w_clr_we  = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            // Carry into the extra bit marks the last address just written.
            if (w_cnt_nxt[AW]) w_state_nxt = S_READY;
         end
         default: ;
      endcase
   end

   // The clear sequencer owns the write port while busy; user requests are ignored.
   assign w_we      = w_clr_we | (i_wen & ~o_busy);
   assign w_wbe     = w_clr_we ? {NB{1'b1}} : i_wbe;
   assign w_waddr   = w_clr_we ? r_cnt[AW-1:0] : i_waddr;
   assign w_wdata   = w_clr_we ? '0 : i_wd;
   assign w_ren_acc = i_ren & ~o_busy;
   assign w_fwd     = {NB{i_wen & ~o_busy & (i_waddr == i_raddr)}} & i_wbe;

   // NOTE: the array has no reset; clearing is done by the sequencer so the
   // storage still maps onto plain RAM blocks.
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_d1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= w_ren_acc;
         if (w_ren_acc) begin
            for (int b = 0; b < NB; b++) begin
               r_d1[8*b +: 8] <= w_fwd[b] ? i_wd[8*b +: 8] : r_mem[i_raddr][8*b +: 8];
            end
         end
      end
   end

   if (RD_PIPE != 0) begin : g_pipe
      logic [DW-1:0] r_d2;
      logic          r_v2;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_d2 <= '0;
            r_v2 <= 1'b0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) r_d2 <= r_d1;
         end
      end

      assign o_rd     = r_d2;
      assign o_rvalid = r_v2;
   end else begin : g_nopipe
      assign o_rd     = r_d1;
      assign o_rvalid = r_v1;
   end

endmodule
